bcd_counter_4dig: RTL and testbench
===================================

Name: bcd_counter_4dig

Overview:
- Four-digit BCD up/down counter that advances once per prescaled tick.
- Drives the units/tens/hundreds/thousands inputs of the downstream 7-segment multiplex display stage.
- Contains its own prescaler so the count rate is independent of the display refresh rate.
- Emits a one-cycle wrap pulse for cascading or event logging.

Parameters:
- TICK_DIV, 5000000, CLK cycles per count tick (10 Hz at 50 MHz); legal range 2 to 2^24.
- PRESC_W, 24, prescaler register width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  count enable; low freezes the prescaler and the digits.
- UP  input  1  direction: 1 counts up, 0 counts down; sampled on the tick cycle.
- CLR  input  1  synchronous clear of the digits and the prescaler.
- units  output  4  BCD digit 0 (registered).
- tens  output  4  BCD digit 1 (registered).
- hundreds  output  4  BCD digit 2 (registered).
- thousands  output  4  BCD digit 3 (registered).
- TICK  output  1  one-cycle pulse on every count step.
- WRAP  output  1  one-cycle pulse, coincident with the digit update, on 9999->0000 (up) or 0000->9999 (down).

Behaviour:
- Reset: RST_N low asynchronously forces the following to zero:
  - prescaler;
  - all four digits;
  - TICK;
  - WRAP.
  Registers release on the first CLK edge after RST_N rises.
- Prescaler:
  - When EN=1, increments each cycle.
  - When it equals TICK_DIV-1, it returns to 0 and the cycle is a tick cycle.
  - When EN=0, it holds its value.
- Tick cycle: at the same edge,
  - the digits update;
  - TICK is registered high for exactly one cycle;
  - latency from the terminal prescaler value to the new digits is 1 cycle.
- Up step:
  - units+1; a digit at 9 becomes 0 and carries into the next digit.
  - Carry ripples combinationally inside a single cycle, so all digits change on the same edge.
- Down step:
  - units-1; a digit at 0 becomes 9 and borrows from the next digit.
- WRAP: high for the one cycle after the edge where every digit rolls over (up at 9999, down at 0000). Otherwise low.
- CLR:
  - Highest priority after reset.
  - Clears digits and prescaler at the next edge and suppresses TICK/WRAP that cycle, even if it is a tick cycle.
- EN falling mid-interval: prescaler keeps its partial count; counting resumes from there when EN returns.
- UP changing between ticks: takes effect on the next tick only. No glitch and no extra step.
- Digits never hold values 10-15; no illegal-value recovery logic is required.
- Outputs are held stable between ticks, so the downstream multiplexer may sample them at any time.

Optional Feature:
- Macro: BCD_LOAD_EN.
- When defined, adds these ports:
  - LOAD (input, 1): synchronous load strobe;
  - LOAD_VAL (input, 16): BCD load value, {thousands,tens-of-hundreds...} packed as [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- LOAD behaviour:
  - LOAD=1 copies LOAD_VAL into the digits at the next edge and resets the prescaler.
  - Priority: RST_N > CLR > LOAD > tick.
  - TICK and WRAP are suppressed in the load cycle.
  - Any LOAD_VAL nibble above 9 is saturated to 9.
- When not defined, the ports do not exist and the block behaves exactly as described above.

Decomposition:
- Shared package bcd_pkg with:
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0;
  - a typedef for a 4-bit BCD digit;
  - the packed 16-bit LOAD_VAL layout.
- One sub-module, bcd_digit, instantiated four times.
  - Ports: clk, rst_n, step, up, clr, digit out, roll out.
  - It does one-decade increment/decrement with a combinational roll signal that is ANDed with step into the next instance.
- The prescaler and the TICK/WRAP registers live in the top.

Test Plan:
- Reset mid-count: with TICK_DIV=4, assert RST_N=0 at count 0042 -> all digits, TICK and WRAP read 0 immediately, without waiting for a CLK edge.
- Up rollover: EN=1, UP=1, start from 0009, then from 9999 ->
  - 0009 steps to 0010;
  - 9999 steps to 0000 with WRAP=1 for exactly one cycle, aligned with TICK.
- Down borrow: UP=0 from 0100 -> 0099. UP=0 from 0000 -> 9999 with WRAP=1.
- Enable freeze: drop EN for 10 cycles, 2 cycles into an interval -> digits hold, and the next TICK arrives 2 cycles after EN returns (prescaler preserved).
- CLR on a tick cycle: assert CLR exactly when the prescaler is at TICK_DIV-1 with count 0555 -> digits become 0000 and TICK=0 that cycle.
- BCD_LOAD_EN: LOAD with LOAD_VAL=16'h12F4 -> digits read 1,2,9,4 (nibble saturated); next up tick -> 1,2,9,5.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the four-digit BCD counter: digit type, digit limits
// and the packed 16-bit load word layout.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    typedef struct packed {
        bcd_t thousands;
        bcd_t hundreds;
        bcd_t tens;
        bcd_t units;
    } bcd_word_t;

    // Clamp a raw nibble into the legal BCD range.
    function automatic bcd_t bcd_sat(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increments/decrements on step, exposes a combinational roll
// flag that the parent chains into the next decade. Load port exists only with BCD_LOAD_EN.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic up,
    input  logic clr,
`ifdef BCD_LOAD_EN
    input  logic load,
    input  bcd_t load_val,
`endif
    output bcd_t digit,
    output logic roll
);

    // roll means "this decade wraps if stepped now" in the current direction.
    always_comb begin
        roll = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= BCD_MIN;
        end else if (clr) begin
            digit <= BCD_MIN;
`ifdef BCD_LOAD_EN
        end else if (load) begin
            digit <= bcd_sat(load_val);
`endif
        end else if (step) begin
            if (roll) begin
                digit <= up ? BCD_MIN : BCD_MAX;
            end else begin
                digit <= up ? digit + 4'd1 : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD up/down counter with built-in prescaler, TICK and WRAP pulses.
// Define BCD_LOAD_EN to add the LOAD/LOAD_VAL synchronous preset ports.
module bcd_counter_4dig
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int PRESC_W  = 24
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       UP,
    input  logic       CLR,
`ifdef BCD_LOAD_EN
    input  logic       LOAD,
    input  logic [15:0] LOAD_VAL,
`endif
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic       TICK,
    output logic       WRAP
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               terminal;
    logic               load_req;
    logic               tick_cyc;
    logic [3:0]         step;
    logic [3:0]         roll;
    bcd_t               dig [4];

`ifdef BCD_LOAD_EN
    assign load_req = LOAD;
`else
    assign load_req = 1'b0;
`endif

    // CLR and LOAD both steal the tick cycle, so no step and no pulses.
    assign terminal = EN && (presc == PRESC_LAST);
    assign tick_cyc = terminal && !CLR && !load_req;

    // Carry/borrow ripples combinationally so all decades move on one edge.
    assign step[0] = tick_cyc;
    assign step[1] = step[0] & roll[0];
    assign step[2] = step[1] & roll[1];
    assign step[3] = step[2] & roll[2];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (CLK),
            .rst_n    (RST_N),
            .step     (step[i]),
            .up       (UP),
            .clr      (CLR),
`ifdef BCD_LOAD_EN
            .load     (LOAD),
            .load_val (LOAD_VAL[4*i +: 4]),
`endif
            .digit    (dig[i]),
            .roll     (roll[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
            TICK  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            TICK <= tick_cyc;
            WRAP <= step[3] & roll[3];
            if (CLR || load_req) begin
                presc <= '0;
            end else if (EN) begin
                presc <= terminal ? '0 : presc + 1'b1;
            end
        end
    end

    assign units     = dig[0];
    assign tens      = dig[1];
    assign hundreds  = dig[2];
    assign thousands = dig[3];

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// Directed bench for bcd_counter_4dig with a short prescaler (TICK_DIV=4).
// Define BCD_LOAD_EN to also exercise the load port.
module tb_bcd_counter_4dig;

    localparam int TICK_DIV = 4;
    localparam int PRESC_W  = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;
`ifdef BCD_LOAD_EN
    logic       load;
    logic [15:0] load_val;
`endif
    logic [3:0] units, tens, hundreds, thousands;
    logic       tick;
    logic       wrap;
    logic [15:0] dval;

    int vectors;
    int miscompares;

    assign dval = {thousands, hundreds, tens, units};

    bcd_counter_4dig #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (PRESC_W)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .EN        (en),
        .UP        (up),
        .CLR       (clr),
`ifdef BCD_LOAD_EN
        .LOAD      (load),
        .LOAD_VAL  (load_val),
`endif
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .TICK      (tick),
        .WRAP      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until TICK is seen; a missing tick within the budget is a miscompare.
    task automatic wait_tick(input int budget, output int n_cyc);
        n_cyc = 0;
        do begin
            cyc();
            n_cyc++;
        end while (!tick && n_cyc < budget);
        vectors++;
        if (tick !== 1'b1) begin
            miscompares++;
            $display("FAIL tick_timeout: no TICK within %0d cycles (value %h)", budget, dval);
        end
    endtask

    task automatic run_ticks(input int n);
        int c;
        repeat (n) wait_tick(8, c);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dval, tick, wrap} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h tick=%b wrap=%b, want 0000 0 0", dval, tick, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        run_ticks(42);
        vectors++;
        if (dval !== 16'h0042 || tick !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_precount: got %h tick=%b, want 0042 1", dval, tick);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dval, tick, wrap} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_async: got %h tick=%b wrap=%b, want 0000 0 0", dval, tick, wrap);
        end
        #2 rst_n = 1'b1;
        wait_tick(8, c);
        vectors++;
        if (c != TICK_DIV || dval !== 16'h0001) begin
            miscompares++;
            $display("FAIL reset_presc: first tick after %0d cycles value %h, want %0d 0001", c, dval, TICK_DIV);
        end
    endtask

    task automatic test_up_rollover();
        int c;
        do_clr();
        up = 1'b1;
        run_ticks(9);
        vectors++;
        if (dval !== 16'h0009) begin
            miscompares++;
            $display("FAIL up_0009: got %h want 0009", dval);
        end
        wait_tick(8, c);
        vectors++;
        if (dval !== 16'h0010 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL up_carry: got %h wrap=%b want 0010 0", dval, wrap);
        end
    endtask

    task automatic test_down_borrow();
        int c;
        run_ticks(90);
        vectors++;
        if (dval !== 16'h0100) begin
            miscompares++;
            $display("FAIL down_pre: got %h want 0100", dval);
        end
        up = 1'b0;
        wait_tick(8, c);
        vectors++;
        if (dval !== 16'h0099 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL down_borrow: got %h wrap=%b want 0099 0", dval, wrap);
        end
        do_clr();
        vectors++;
        if (dval !== 16'h0000 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_plain: got %h tick=%b want 0000 0", dval, tick);
        end
        wait_tick(8, c);
        vectors++;
        if (dval !== 16'h9999 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL down_wrap: got %h wrap=%b want 9999 1", dval, wrap);
        end
        cyc();
        vectors++;
        if (dval !== 16'h9999 || wrap !== 1'b0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL down_wrap_pulse: got %h tick=%b wrap=%b want 9999 0 0", dval, tick, wrap);
        end
        up = 1'b1;
        wait_tick(8, c);
        vectors++;
        if (dval !== 16'h0000 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL up_wrap: got %h wrap=%b want 0000 1", dval, wrap);
        end
        cyc();
        vectors++;
        if (wrap !== 1'b0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL up_wrap_pulse: tick=%b wrap=%b want 0 0", tick, wrap);
        end
    endtask

    task automatic test_enable_freeze();
        int  c;
        bit  moved;
        wait_tick(8, c);
        cyc();
        cyc();
        en    = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick !== 1'b0 || dval !== 16'h0001) moved = 1'b1;
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("FAIL en_freeze: counter moved while EN=0 (value %h), want hold 0001", dval);
        end
        en = 1'b1;
        cyc();
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++;
            $display("FAIL en_resume_early: tick=%b one cycle after EN, want 0", tick);
        end
        cyc();
        vectors++;
        if (tick !== 1'b1 || dval !== 16'h0002) begin
            miscompares++;
            $display("FAIL en_resume: tick=%b value %h two cycles after EN, want 1 0002", tick, dval);
        end
    endtask

    task automatic test_clr_on_tick();
        int c;
        do_clr();
        run_ticks(555);
        vectors++;
        if (dval !== 16'h0555) begin
            miscompares++;
            $display("FAIL clr_pre: got %h want 0555", dval);
        end
        repeat (TICK_DIV - 1) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        vectors++;
        if (dval !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_tick: got %h tick=%b wrap=%b want 0000 0 0", dval, tick, wrap);
        end
        wait_tick(8, c);
        vectors++;
        if (c != TICK_DIV || dval !== 16'h0001) begin
            miscompares++;
            $display("FAIL clr_presc: tick after %0d cycles value %h, want %0d 0001", c, dval, TICK_DIV);
        end
    endtask

`ifdef BCD_LOAD_EN
    task automatic test_load();
        int c;
        load_val = 16'h12F4;
        load     = 1'b1;
        cyc();
        load     = 1'b0;
        vectors++;
        if (dval !== 16'h1294 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL load_sat: got %h tick=%b want 1294 0", dval, tick);
        end
        wait_tick(8, c);
        vectors++;
        if (c != TICK_DIV || dval !== 16'h1295) begin
            miscompares++;
            $display("FAIL load_step: tick after %0d cycles value %h, want %0d 1295", c, dval, TICK_DIV);
        end
        repeat (TICK_DIV - 1) cyc();
        load_val = 16'hA0B3;
        load     = 1'b1;
        cyc();
        load     = 1'b0;
        vectors++;
        if (dval !== 16'h9093 || tick !== 1'b0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL load_on_tick: got %h tick=%b wrap=%b want 9093 0 0", dval, tick, wrap);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b1;
        en    = 1'b0;
        up    = 1'b1;
        clr   = 1'b0;
`ifdef BCD_LOAD_EN
        load     = 1'b0;
        load_val = 16'h0000;
`endif
        test_reset();
        test_up_rollover();
        test_down_borrow();
        test_enable_freeze();
        test_clr_on_tick();
`ifdef BCD_LOAD_EN
        test_load();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
